// File: rtl/sqm_pkg.sv
// Shared types for the sqm vector capture path: the 28-bit packed vector
// layout and the recorder state encoding.
package sqm_pkg;

  localparam int VEC_W = 28;

  typedef struct packed {
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] c;
    logic [7:0] y;
  } sqm_vec_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REC  = 2'd1,
    DONE = 2'd2
  } rec_state_t;

  function automatic sqm_vec_t pack_vec(input logic [7:0] a_i, input logic [3:0] b_i,
                                        input logic [7:0] c_i, input logic [7:0] y_i);
    sqm_vec_t v_s;
    v_s.a = a_i;
    v_s.b = b_i;
    v_s.c = c_i;
    v_s.y = y_i;
    return v_s;
  endfunction

endpackage

// File: rtl/sqm_fifo.sv
// Synchronous first-word-fall-through FIFO of packed sqm vectors.
// Writes while full and reads while empty are dropped internally.
module sqm_fifo
  import sqm_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     wr_en,
  input  sqm_vec_t                 wr_data,
  input  logic                     rd_en,
  output sqm_vec_t                 rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  sqm_vec_t          mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic              do_wr_s;
  logic              do_rd_s;

  assign full    = (count_r == FULL_CNT);
  assign empty   = (count_r == {CW{1'b0}});
  assign do_wr_s = wr_en && !full;
  assign do_rd_s = rd_en && !empty;
  assign count   = count_r;
  // Head word is forced to zero when empty so stale storage never shows.
  assign rd_data = empty ? sqm_vec_t'({VEC_W{1'b0}}) : mem_r[rd_ptr_r];

  // Storage array; contents need no reset because empty masks the output.
  always_ff @(posedge clk) begin
    if (do_wr_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_wr_s) begin
        wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      if (do_rd_s) begin
        rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      case ({do_wr_s, do_rd_s})
        2'b10:   count_r <= count_r + {{AW{1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{AW{1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/sqm_vector_recorder.sv
// Captures live {a,b,c,y} tuples into a FIFO while armed and streams them
// out over valid/ready; tracks refused tuples with a sticky overflow flag.
module sqm_vector_recorder
  import sqm_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int VEC_W = 28
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     clear,
  input  logic                     cap_valid,
  input  logic [7:0]               a,
  input  logic [3:0]               b,
  input  logic [7:0]               c,
  input  logic [7:0]               y,
  output logic                     cap_ready,
  output logic                     rd_valid,
  output logic [VEC_W-1:0]         rd_data,
  input  logic                     rd_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [1:0]               state
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(DEPTH - 1);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);
  localparam logic [CW-1:0] ZERO_CNT = CW'(0);

  rec_state_t        state_r;
  rec_state_t        state_nxt_s;
  logic              overflow_r;
  logic              wr_en_s;
  logic              rd_en_s;
  logic              full_s;
  logic              empty_s;
  logic [CW-1:0]     count_s;
  sqm_vec_t          wr_vec_s;
  sqm_vec_t          rd_vec_s;

  assign wr_vec_s  = pack_vec(a, b, c, y);
  assign cap_ready = (state_r == REC) && !full_s;
  assign wr_en_s   = cap_valid && cap_ready;
  assign rd_valid  = !empty_s;
  assign rd_en_s   = rd_valid && rd_ready;
  assign rd_data   = rd_vec_s;
  assign count     = count_s;
  assign overflow  = overflow_r;
  assign state     = state_r;

  sqm_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .wr_en   (wr_en_s),
    .wr_data (wr_vec_s),
    .rd_en   (rd_en_s),
    .rd_data (rd_vec_s),
    .count   (count_s),
    .full    (full_s),
    .empty   (empty_s)
  );

  // Recorder next-state decision.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nxt_s = REC;
        else       state_nxt_s = IDLE;
      end
      REC: begin
        // A write paired with a pop leaves occupancy unchanged, so it cannot fill.
        if (stop)                                              state_nxt_s = DONE;
        else if (wr_en_s && !rd_en_s && count_s == LAST_CNT)   state_nxt_s = DONE;
        else                                                   state_nxt_s = REC;
      end
      DONE: begin
        if (count_s == ZERO_CNT || (count_s == ONE_CNT && rd_en_s)) state_nxt_s = IDLE;
        else                                                        state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Sticky overflow: a tuple offered while armed or draining but not taken.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      overflow_r <= 1'b0;
    end else if (cap_valid && !cap_ready && state_r != IDLE) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end

endmodule

// File: tb/tb_sqm_vector_recorder.sv
// Scoreboard bench for sqm_vector_recorder: a small reference model predicts
// state/count/flags and queues expected words that are compared as they pop.
module tb_sqm_vector_recorder;

  logic        clk = 1'b0;
  logic        reset, start, stop, clear, cap_valid, rd_ready;
  logic [7:0]  a, c, y;
  logic [3:0]  b;
  logic        cap_ready, rd_valid, overflow;
  logic [27:0] rd_data;
  logic [4:0]  count;
  logic [1:0]  state;

  int n_cmp = 0;
  int n_err = 0;

  logic [27:0] exp_q[$];
  int          m_state, m_count;
  logic        m_ovf;

  sqm_vector_recorder #(.DEPTH(16), .VEC_W(28)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .cap_valid(cap_valid), .a(a), .b(b), .c(c), .y(y),
    .cap_ready(cap_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_ready(rd_ready), .count(count), .overflow(overflow), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, compare outputs to the model, advance both.
  task automatic tick(input logic st, input logic sp, input logic cl, input logic rs,
                      input logic cv, input logic [7:0] ai, input logic [3:0] bi,
                      input logic [7:0] ci, input logic [7:0] yi, input logic rr);
    logic cr, wr, rd;
    start = st; stop = sp; clear = cl; reset = rs; cap_valid = cv;
    a = ai; b = bi; c = ci; y = yi; rd_ready = rr;
    #1;
    check_val("state", {30'd0, state}, m_state);
    check_val("count", {27'd0, count}, m_count);
    check_val("cap_ready", {31'd0, cap_ready}, {31'd0, (m_state == 1 && m_count != 16)});
    check_val("rd_valid", {31'd0, rd_valid}, {31'd0, (m_count != 0)});
    check_val("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    if (exp_q.size() != 0) check_val("rd_data", {4'd0, rd_data}, {4'd0, exp_q[0]});
    else                   check_val("rd_data_empty", {4'd0, rd_data}, 32'd0);
    @(posedge clk);
    if (rs || cl) begin
      m_state = 0; m_count = 0; m_ovf = 1'b0; exp_q.delete();
    end else begin
      cr = (m_state == 1) && (m_count != 16);
      wr = cv && cr;
      rd = (m_count != 0) && rr;
      if (cv && !cr && m_state != 0) m_ovf = 1'b1;
      if (rd) void'(exp_q.pop_front());
      if (wr) exp_q.push_back({ai, bi, ci, yi});
      case (m_state)
        0: if (st) m_state = 1;
        1: if (sp) m_state = 2;
           else if (wr && !rd && m_count == 15) m_state = 2;
        2: if (m_count - int'(rd) == 0) m_state = 0;
        default: m_state = 0;
      endcase
      m_count = m_count + int'(wr) - int'(rd);
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic rr);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 8'h00, 8'h00, rr);
  endtask

  task automatic cap(input logic [7:0] yi, input logic rr);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 4'h9, 8'hC3, yi, rr);
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && m_count != 0; k++) idle(1'b1);
    idle(1'b0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; cap_valid = 1'b0;
    a = 8'h00; b = 4'h0; c = 8'h00; y = 8'h00; rd_ready = 1'b0;
    m_state = 0; m_count = 0; m_ovf = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    reset = 1'b0;
    idle(1'b0);

    // Basic capture
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 8'h00, 8'h00, 1'b0);
    check_val("start_ready", {31'd0, cap_ready}, 32'd1);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 4'h5, 8'hA1, 8'h0F, 1'b0);
    check_val("basic_valid", {31'd0, rd_valid}, 32'd1);
    check_val("basic_data", {4'd0, rd_data}, 32'h03C5A10F);
    check_val("basic_count", {27'd0, count}, 32'd1);
    idle(1'b1);
    check_val("basic_pop_count", {27'd0, count}, 32'd0);
    check_val("basic_pop_valid", {31'd0, rd_valid}, 32'd0);

    // Fill to depth, overflow, simultaneous full write/read, ignored start/stop
    for (int i = 0; i < 16; i++) cap(8'(i), 1'b0);
    check_val("fill_state", {30'd0, state}, 32'd2);
    check_val("fill_ready", {31'd0, cap_ready}, 32'd0);
    cap(8'hEE, 1'b0);
    check_val("fill_ovf", {31'd0, overflow}, 32'd1);
    cap(8'hEF, 1'b1);
    check_val("full_wr_rd_count", {27'd0, count}, 32'd15);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 8'h00, 8'h00, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 8'h00, 8'h00, 1'b0);
    check_val("done_start_ignored", {30'd0, state}, 32'd2);
    drain();
    check_val("drain_idle", {30'd0, state}, 32'd0);

    // Idle gating after a clear
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'h0, 8'h00, 8'h00, 1'b0);
    cap(8'h77, 1'b0);
    check_val("idle_no_ovf", {31'd0, overflow}, 32'd0);
    check_val("idle_no_store", {27'd0, count}, 32'd0);

    // Wrap-around with consumer always ready
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 8'h00, 8'h00, 1'b1);
    for (int i = 0; i < 40; i++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'(i * 3), 4'(i), 8'(255 - i), 8'(i), 1'b1);
      check_val("wrap_count_le1", {31'd0, (count <= 5'd1)}, 32'd1);
    end
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 8'h00, 8'h00, 1'b1);
    drain();

    // Stop after three captures
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) cap(8'(8'h40 + i), 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 8'h00, 8'h00, 1'b0);
    check_val("stop_state", {30'd0, state}, 32'd2);
    check_val("stop_ready", {31'd0, cap_ready}, 32'd0);
    cap(8'h99, 1'b0);
    check_val("stop_ovf", {31'd0, overflow}, 32'd1);
    drain();

    // Clear mid-record wins over start, capture and read
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) cap(8'(8'h60 + i), 1'b0);
    check_val("pre_clear_count", {27'd0, count}, 32'd5);
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 4'h2, 8'h33, 8'h44, 1'b1);
    check_val("clear_count", {27'd0, count}, 32'd0);
    check_val("clear_state", {30'd0, state}, 32'd0);
    check_val("clear_ovf", {31'd0, overflow}, 32'd0);
    check_val("clear_valid", {31'd0, rd_valid}, 32'd0);

    // Same with reset
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) cap(8'(8'h70 + i), 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 4'h2, 8'h33, 8'h44, 1'b1);
    check_val("reset_count", {27'd0, count}, 32'd0);
    check_val("reset_state", {30'd0, state}, 32'd0);
    check_val("reset_ovf", {31'd0, overflow}, 32'd0);
    check_val("reset_valid", {31'd0, rd_valid}, 32'd0);
    idle(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
